// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file writeback controller.
// Holds the data and index widths, the x0 index, the grant encodings and a
// small helper that tells whether a destination index really writes state.
package regfile_wb_arbiter_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // Encoding of the remembered last winner.
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  // Bit positions inside the two-bit grant vector.
  localparam int unsigned GV_A_BIT = 0;
  localparam int unsigned GV_B_BIT = 1;

  // x0 is hardwired to zero, so a write to it changes no architectural state.
  function automatic logic writes_reg(input reg_idx_t idx);
    return (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// wb_rr_arbiter
// Two-requester round-robin arbiter for the register-file write port.
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high; forces the grant vector to zero
//   a_valid_i     ALU request
//   b_valid_i     load-unit request
//   gnt_o         one-hot grant vector, bit 0 = A, bit 1 = B
//   last_grant_o  requester that won most recently (GNT_A / GNT_B)
module wb_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       a_valid_i,
  input  logic       b_valid_i,
  output logic [1:0] gnt_o,
  output logic       last_grant_o
);

  logic       last_grant_q;
  logic       last_grant_d;
  logic [1:0] gnt_s;

  // Grant selection: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    gnt_s = 2'b00;
    if (reset) begin
      gnt_s = 2'b00;
    end else begin
      case ({b_valid_i, a_valid_i})
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (last_grant_q == GNT_A) ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Remember the winner only when a grant is actually issued.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_s[GV_B_BIT]) begin
      last_grant_d = GNT_B;
    end else if (gnt_s[GV_A_BIT]) begin
      last_grant_d = GNT_A;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-winner register; resets to B so that A wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= GNT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt_o        = gnt_s;
  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Writeback controller for the 32x32 register file. Shares the single write
// port between the ALU (A) and the load unit (B) with a round-robin
// valid/ready handshake, registers the winning write, and keeps a
// per-register pending-write scoreboard for the decode stall logic.
// Ports:
//   clock, reset                     clock and synchronous active-high reset
//   a_valid/a_rd/a_result/a_ready    ALU writeback handshake
//   b_valid/b_rd/b_result/b_ready    load-unit writeback handshake
//   issue_valid/issue_rd             decode issued a register-writing instruction
//   write_enable/rd/result           registered drive of the register-file write port
//   pending                          bit i set: register i has an outstanding write
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN,
  parameter int unsigned NREG = 32
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       a_valid,
  input  logic [regfile_wb_arbiter_pkg::REG_IDX_W-1:0] a_rd,
  input  logic [XLEN-1:0]                            a_result,
  output logic                                       a_ready,
  input  logic                                       b_valid,
  input  logic [regfile_wb_arbiter_pkg::REG_IDX_W-1:0] b_rd,
  input  logic [XLEN-1:0]                            b_result,
  output logic                                       b_ready,
  input  logic                                       issue_valid,
  input  logic [regfile_wb_arbiter_pkg::REG_IDX_W-1:0] issue_rd,
  output logic                                       write_enable,
  output logic [regfile_wb_arbiter_pkg::REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]                            result,
  output logic [NREG-1:0]                            pending
);

  import regfile_wb_arbiter_pkg::*;

  logic [1:0]      gnt_s;
  logic            last_grant_s;
  logic            accept_s;
  reg_idx_t        win_rd_s;
  logic [XLEN-1:0] win_result_s;

  logic            write_enable_q;
  logic            write_enable_d;
  reg_idx_t        rd_q;
  reg_idx_t        rd_d;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] result_d;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  wb_rr_arbiter u_arb (
    .clock        (clock),
    .reset        (reset),
    .a_valid_i    (a_valid),
    .b_valid_i    (b_valid),
    .gnt_o        (gnt_s),
    .last_grant_o (last_grant_s)
  );

  assign a_ready  = gnt_s[GV_A_BIT];
  assign b_ready  = gnt_s[GV_B_BIT];
  assign accept_s = |gnt_s;

  // Steer the winner's payload onto the internal write bus.
  always_comb begin
    win_rd_s     = a_rd;
    win_result_s = a_result;
    if (gnt_s[GV_B_BIT]) begin
      win_rd_s     = b_rd;
      win_result_s = b_result;
    end else begin
      win_rd_s     = a_rd;
      win_result_s = a_result;
    end
  end

  // Next write-port state: load on accept, otherwise hold rd/result and drop the enable.
  // An x0 destination still completes the handshake but never raises the enable.
  always_comb begin
    write_enable_d = 1'b0;
    rd_d           = rd_q;
    result_d       = result_q;
    if (accept_s) begin
      write_enable_d = writes_reg(win_rd_s);
      rd_d           = win_rd_s;
      result_d       = win_result_s;
    end else begin
      write_enable_d = 1'b0;
      rd_d           = rd_q;
      result_d       = result_q;
    end
  end

  // Scoreboard next state: clear first, then set, so a same-cycle issue
  // to the index being written back leaves it pending for the new producer.
  always_comb begin
    pending_d = pending_q;
    if (accept_s) begin
      pending_d[win_rd_s] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (issue_valid && writes_reg(issue_rd)) begin
      pending_d[issue_rd] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  // Write-port and scoreboard registers; reset drops any write in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable_q <= 1'b0;
      rd_q           <= REG_ZERO;
      result_q       <= '0;
      pending_q      <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      rd_q           <= rd_d;
      result_q       <= result_d;
      pending_q      <= pending_d;
    end
  end

  assign write_enable = write_enable_q;
  assign rd           = rd_q;
  assign result       = result_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd;
  logic [31:0] a_result, b_result;
  logic        a_ready, b_ready, write_enable;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [31:0] pending;

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_result(a_result), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_result(b_result), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .write_enable(write_enable), .rd(rd), .result(result), .pending(pending)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
  } wr_t;

  wr_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_last = 1'b1;
  logic [4:0]  m_rd   = 5'd0;
  logic [31:0] m_res  = 32'd0;
  logic [31:0] m_pending = 32'd0;

  // Per-step expected and observed values
  logic [1:0]  exp_ready, obs_ready;
  wr_t         exp_wr;
  logic [31:0] exp_pending;

  // One clock of stimulus: drive inputs, predict, sample readies, cross the
  // edge and pop the expected write. No comparisons are made here.
  task automatic step(input logic rst,
                      input logic av, input logic [4:0] ard, input logic [31:0] ares,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bres,
                      input logic iv, input logic [4:0] ird);
    logic [1:0]  g;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] p;
    @(negedge clock);
    reset = rst;
    a_valid = av; a_rd = ard; a_result = ares;
    b_valid = bv; b_rd = brd; b_result = bres;
    issue_valid = iv; issue_rd = ird;
    if (rst)            g = 2'b00;
    else if (av && bv)  g = m_last ? 2'b01 : 2'b10;
    else                g = {bv, av};
    wrd  = g[1] ? brd  : ard;
    wres = g[1] ? bres : ares;
    if (rst) begin
      exp_q.push_back('{we: 1'b0, rd: 5'd0, res: 32'd0});
      m_last = 1'b1; m_rd = 5'd0; m_res = 32'd0; m_pending = 32'd0;
    end else begin
      p = m_pending;
      if (g != 2'b00) begin
        exp_q.push_back('{we: (wrd != 5'd0), rd: wrd, res: wres});
        m_last = g[1]; m_rd = wrd; m_res = wres;
        p[wrd] = 1'b0;
      end else begin
        exp_q.push_back('{we: 1'b0, rd: m_rd, res: m_res});
      end
      if (iv && ird != 5'd0) p[ird] = 1'b1;
      p[0] = 1'b0;
      m_pending = p;
    end
    exp_ready = g;
    #1;
    obs_ready = {b_ready, a_ready};
    @(posedge clock);
    #1;
    exp_wr = exp_q.pop_front();
    exp_pending = m_pending;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 5'd3);
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 5'd3);
    n_checks++; if (obs_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", obs_ready); end
    n_checks++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", write_enable); end
    n_checks++; if (rd !== 5'd0 || result !== 32'd0) begin n_fail++; $display("FAIL reset_rd_result: got %0d/%h expected 0/0", rd, result); end
    n_checks++; if (pending !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", pending); end
  endtask

  task automatic test_solo_alu();
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    n_checks++; if (obs_ready !== 2'b01 || obs_ready !== exp_ready) begin n_fail++; $display("FAIL solo_ready: got %b expected %b", obs_ready, exp_ready); end
    n_checks++; if ({write_enable, rd, result} !== {1'b1, 5'd5, 32'hDEADBEEF} || {write_enable, rd, result} !== exp_wr) begin
      n_fail++; $display("FAIL solo_write: got we=%b rd=%0d res=%h expected we=1 rd=5 res=deadbeef", write_enable, rd, result); end
    idle();
    n_checks++; if (write_enable !== 1'b0 || rd !== exp_wr.rd || result !== exp_wr.res) begin
      n_fail++; $display("FAIL solo_after: got we=%b rd=%0d res=%h expected we=0 rd=%0d res=%h", write_enable, rd, result, exp_wr.rd, exp_wr.res); end
  endtask

  task automatic test_contention();
    logic [4:0] want_rd [3];
    logic [1:0] want_g  [3];
    want_rd[0] = 5'd1; want_rd[1] = 5'd2; want_rd[2] = 5'd3;
    want_g[0]  = 2'b01; want_g[1] = 2'b10; want_g[2] = 2'b01;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       step(1'b0, 1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b0, 5'd0);
        1:       step(1'b0, 1'b1, 5'd3, 32'd3, 1'b1, 5'd2, 32'd2, 1'b0, 5'd0);
        default: step(1'b0, 1'b1, 5'd3, 32'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      endcase
      n_checks++; if (obs_ready !== want_g[i] || obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL contention_grant[%0d]: got %b expected %b", i, obs_ready, want_g[i]); end
      n_checks++; if (write_enable !== 1'b1 || rd !== want_rd[i] || result !== {27'd0, want_rd[i]}) begin
        n_fail++; $display("FAIL contention_write[%0d]: got we=%b rd=%0d res=%h expected we=1 rd=%0d", i, write_enable, rd, result, want_rd[i]); end
    end
    idle();
  endtask

  task automatic test_x0_discard();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd7, 1'b0, 5'd0);
    n_checks++; if (obs_ready !== 2'b10) begin n_fail++; $display("FAIL x0_ready: got %b expected 10", obs_ready); end
    n_checks++; if (write_enable !== 1'b0 || write_enable !== exp_wr.we) begin n_fail++; $display("FAIL x0_we: got %b expected 0", write_enable); end
    n_checks++; if (pending !== exp_pending || pending[6] !== 1'b1 || pending[0] !== 1'b0) begin
      n_fail++; $display("FAIL x0_pending: got %h expected %h", pending, exp_pending); end
  endtask

  task automatic test_scoreboard();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    n_checks++; if (pending[4] !== 1'b1 || pending !== exp_pending) begin n_fail++; $display("FAIL sb_set: got %h expected %h", pending, exp_pending); end
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    n_checks++; if (pending[0] !== 1'b0 || pending !== exp_pending) begin n_fail++; $display("FAIL sb_x0_issue: got %h expected %h", pending, exp_pending); end
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    n_checks++; if (pending[4] !== 1'b0 || pending !== exp_pending) begin n_fail++; $display("FAIL sb_clear: got %h expected %h", pending, exp_pending); end
    step(1'b0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    n_checks++; if (pending[4] !== 1'b1 || pending !== exp_pending) begin n_fail++; $display("FAIL sb_set_wins: got %h expected %h", pending, exp_pending); end
    n_checks++; if (write_enable !== 1'b1 || rd !== 5'd4 || result !== 32'h45) begin
      n_fail++; $display("FAIL sb_write: got we=%b rd=%0d res=%h expected we=1 rd=4 res=45", write_enable, rd, result); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    n_checks++; if (write_enable !== 1'b1 || rd !== 5'd9) begin n_fail++; $display("FAIL mid_accept: got we=%b rd=%0d expected we=1 rd=9", write_enable, rd); end
    step(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8);
    n_checks++; if (obs_ready !== 2'b00) begin n_fail++; $display("FAIL mid_ready: got %b expected 00", obs_ready); end
    n_checks++; if (write_enable !== 1'b0 || pending !== 32'd0) begin n_fail++; $display("FAIL mid_reset_state: got we=%b pending=%h expected 0/0", write_enable, pending); end
    step(1'b0, 1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    n_checks++; if (obs_ready !== 2'b01 || obs_ready !== exp_ready) begin n_fail++; $display("FAIL mid_first_tie: got %b expected 01", obs_ready); end
    n_checks++; if ({write_enable, rd, result} !== exp_wr) begin
      n_fail++; $display("FAIL mid_first_write: got we=%b rd=%0d res=%h expected we=%b rd=%0d res=%h", write_enable, rd, result, exp_wr.we, exp_wr.rd, exp_wr.res); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa, pb, last_res;
    logic [1:0]  last_g;
    int          na, nb, writes;
    pa = 32'hA000_0000; pb = 32'hB000_0000; na = 0; nb = 0; writes = 0;
    last_g = 2'b00; last_res = 32'hFFFF_FFFF;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 5'd10, pa, 1'b1, 5'd11, pb, 1'b0, 5'd0);
      n_checks++; if (!$onehot(obs_ready) || obs_ready !== exp_ready || obs_ready === last_g) begin
        n_fail++; $display("FAIL b2b_grant[%0d]: got %b expected %b (prev %b)", i, obs_ready, exp_ready, last_g); end
      n_checks++; if ({write_enable, rd, result} !== exp_wr || result === last_res) begin
        n_fail++; $display("FAIL b2b_write[%0d]: got we=%b rd=%0d res=%h expected rd=%0d res=%h", i, write_enable, rd, result, exp_wr.rd, exp_wr.res); end
      if (write_enable === 1'b1) writes++;
      last_g = obs_ready; last_res = result;
      if (obs_ready[0]) begin na++; pa = 32'hA000_0000 + na; end
      else begin nb++; pb = 32'hB000_0000 + nb; end
    end
    n_checks++; if (writes != 6 || na != 3 || nb != 3) begin
      n_fail++; $display("FAIL b2b_count: got writes=%0d a=%0d b=%0d expected 6/3/3", writes, na, nb); end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_rd = 5'd0; a_result = 32'd0;
    b_valid = 1'b0; b_rd = 5'd0; b_result = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    test_reset();
    test_solo_alu();
    test_contention();
    test_x0_discard();
    test_scoreboard();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
